// File: rtl/kart_pkg.sv
// Shared types, widths and trig-table generator for the kart motion block.
package kart_pkg;

  typedef enum logic [2:0] {IDLE, TURN, SPEED, FETCH0, FETCH1, MOVE} state_t;

  localparam int INT_W      = 11;
  localparam int FRAC_W     = 9;
  localparam int FP_W       = INT_W + FRAC_W;
  localparam int TRIG_W     = 11;
  localparam int TRIG_SCALE = 511;
  localparam int DEG_MAX    = 360;

  // pi in Q30, used only while building the tables at elaboration
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(TRIG_SCALE * sin/cos(deg)), half away from zero. Integer Taylor
  // series in Q30 so the tables fold to constants without real math. The
  // small bias keeps exact halves (sin 30) from landing a hair low.
  function automatic logic signed [TRIG_W-1:0] trig_val(input int deg, input bit is_cos);
    int     a, q;
    bit     neg;
    longint x, x2, term, sum, mag;
    a = is_cos ? (deg + 90) % DEG_MAX : deg;
    if (a <= 90)       begin q = a;       neg = 1'b0; end
    else if (a <= 180) begin q = 180 - a; neg = 1'b0; end
    else if (a <= 270) begin q = a - 180; neg = 1'b1; end
    else               begin q = 360 - a; neg = 1'b1; end
    x    = longint'(q) * PI_Q30 / 64'sd180;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    mag = (sum * longint'(TRIG_SCALE) + (64'sd1 <<< 29) + (64'sd1 <<< 17)) >>> 30;
    if (neg) mag = -mag;
    return TRIG_W'(mag);
  endfunction

  // saturate a widened signed position sum back into unsigned 11.9
  function automatic logic [FP_W-1:0] clamp_fp(input logic signed [FP_W+1:0] v);
    if (v < 0)                                   return '0;
    else if (v > $signed({2'b00, {FP_W{1'b1}}})) return '1;
    else                                         return v[FP_W-1:0];
  endfunction

endpackage

// File: rtl/kart_trig_rom.sv
// 360-entry sin/cos ROM pair sharing one degree address, 2-cycle read latency.
module kart_trig_rom
  import kart_pkg::*;
(
  input  logic                     clk,
  input  logic [8:0]               addr,
  output logic signed [TRIG_W-1:0] sin_q,
  output logic signed [TRIG_W-1:0] cos_q
);

  logic signed [TRIG_W-1:0] sin_tab [DEG_MAX];
  logic signed [TRIG_W-1:0] cos_tab [DEG_MAX];
  logic signed [TRIG_W-1:0] sin_s1, cos_s1;

  for (genvar a = 0; a < DEG_MAX; a++) begin : g_tab
    localparam logic signed [TRIG_W-1:0] SIN_V = trig_val(a, 1'b0);
    localparam logic signed [TRIG_W-1:0] COS_V = trig_val(a, 1'b1);
    assign sin_tab[a] = SIN_V;
    assign cos_tab[a] = COS_V;
  end

  // lookup register then output register
  always_ff @(posedge clk) begin
    sin_s1 <= sin_tab[addr];
    cos_s1 <= cos_tab[addr];
    sin_q  <= sin_s1;
    cos_q  <= cos_s1;
  end

endmodule

// File: rtl/kart_motion.sv
// Per-frame kart heading/speed/position update: turn, speed, trig fetch, move.
module kart_motion
  import kart_pkg::*;
#(
  parameter int START_X   = 1024,
  parameter int START_Y   = 1024,
  parameter int START_DIR = 0,
  parameter int MAX_SPEED = 15,
  parameter int TURN_STEP = 3
)(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_accel_in,
  input  logic        btn_brake_in,
  output logic [8:0]  direction,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic [4:0]  speed_out,
  output logic        busy_out,
  output logic        update_done_out
);

  localparam logic [FP_W-1:0] X0       = FP_W'(START_X) << FRAC_W;
  localparam logic [FP_W-1:0] Y0       = FP_W'(START_Y) << FRAC_W;
  localparam logic [8:0]      DIR0     = 9'(START_DIR);
  localparam logic [4:0]      SPD_MAX  = 5'(MAX_SPEED);
  localparam logic [9:0]      STEP     = 10'(TURN_STEP);
  localparam logic [9:0]      DEG_WRAP = 10'(DEG_MAX);

  state_t state, state_nxt;

  logic [FP_W-1:0] x_fp, y_fp;
  logic [8:0]      dir_w;
  logic [4:0]      spd_w;
  logic            b_left, b_right, b_accel, b_brake, coast;
  logic [1:0]      fcnt;

  logic signed [TRIG_W-1:0] sin_q, cos_q;
  logic [9:0]               dir_l, dir_r;
  logic [8:0]               dir_turn;
  logic [4:0]               spd_new;
  logic signed [16:0]       prod_x, prod_y;
  logic signed [FP_W+1:0]   sum_x, sum_y;

  // working heading feeds the ROM; it is settled from SPEED onward
  kart_trig_rom u_rom (
    .clk   (clk_in),
    .addr  (dir_w),
    .sin_q (sin_q),
    .cos_q (cos_q)
  );

  assign player_x = x_fp[FP_W-1:FRAC_W];
  assign player_y = y_fp[FP_W-1:FRAC_W];

  // candidate heading; turning needs the kart to be moving
  always_comb begin
    dir_l = {1'b0, direction} + DEG_WRAP - STEP;
    if (dir_l >= DEG_WRAP) dir_l = dir_l - DEG_WRAP;
    dir_r = {1'b0, direction} + STEP;
    if (dir_r >= DEG_WRAP) dir_r = dir_r - DEG_WRAP;
    dir_turn = direction;
    if (speed_out != '0) begin
      if (b_left && !b_right)      dir_turn = dir_l[8:0];
      else if (b_right && !b_left) dir_turn = dir_r[8:0];
    end
  end

  // candidate speed: brake beats accel beats periodic coast
  always_comb begin
    spd_new = speed_out;
    if (b_brake)                       spd_new = (speed_out >= 5'd2) ? speed_out - 5'd2 : 5'd0;
    else if (b_accel)                  spd_new = (speed_out >= SPD_MAX) ? SPD_MAX : speed_out + 5'd1;
    else if (coast && speed_out != '0) spd_new = speed_out - 5'd1;
  end

  // full-width signed step; heading 0 is +y so x moves by -sin
  always_comb begin
    prod_x = 17'($signed({1'b0, spd_w})) * 17'(sin_q);
    prod_y = 17'($signed({1'b0, spd_w})) * 17'(cos_q);
    sum_x  = $signed({2'b00, x_fp}) - 22'(prod_x);
    sum_y  = $signed({2'b00, y_fp}) + 22'(prod_y);
  end

  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // fixed walk through the update; extra frame pulses are dropped
  always_comb begin
    state_nxt = state;
    busy_out  = 1'b1;
    unique case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (frame_in) state_nxt = TURN;
      end
      TURN:    state_nxt = SPEED;
      SPEED:   state_nxt = FETCH0;
      FETCH0:  state_nxt = FETCH1;
      FETCH1:  state_nxt = MOVE;
      MOVE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: latch inputs, build working values, commit everything at once
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_fp            <= X0;
      y_fp            <= Y0;
      direction       <= DIR0;
      speed_out       <= '0;
      dir_w           <= DIR0;
      spd_w           <= '0;
      b_left          <= 1'b0;
      b_right         <= 1'b0;
      b_accel         <= 1'b0;
      b_brake         <= 1'b0;
      coast           <= 1'b0;
      fcnt            <= '0;
      update_done_out <= 1'b0;
    end else begin
      update_done_out <= 1'b0;
      case (state)
        IDLE: if (frame_in) begin
          b_left  <= btn_left_in;
          b_right <= btn_right_in;
          b_accel <= btn_accel_in;
          b_brake <= btn_brake_in;
          coast   <= (fcnt == 2'd3);
          fcnt    <= fcnt + 2'd1;
        end
        TURN:  dir_w <= dir_turn;
        SPEED: spd_w <= spd_new;
        MOVE: begin
          x_fp            <= clamp_fp(sum_x);
          y_fp            <= clamp_fp(sum_y);
          direction       <= dir_w;
          speed_out       <= spd_w;
          update_done_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
